// File: rtl/data_ram_pkg.sv
// Shared encodings and helpers for the RV32 data RAM controller.
// Access-size codes, controller state, and the byte-lane enable decode.
package data_ram_pkg;

  localparam logic [1:0] HB_WORD = 2'b00;
  localparam logic [1:0] HB_BYTE = 2'b01;
  localparam logic [1:0] HB_HALF = 2'b10;
  localparam logic [1:0] HB_RSVD = 2'b11;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic [3:0] lane_en(input logic [1:0] hb, input logic [1:0] off);
    logic [3:0] en;
    en = 4'b0000;
    case (hb)
      HB_WORD: en = 4'b1111;
      HB_BYTE: en = 4'b0001 << off;
      HB_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load-data formatter: selects the addressed byte/half of a read word,
// right-justifies it and sign- or zero-extends it to 32 bits.
module mem_load_fmt
  import data_ram_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  hb_i,
  input  logic        uload_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {off_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (hb_i)
      HB_WORD: data_o = word_i;
      HB_BYTE: data_o = {{24{~uload_i & shifted[7]}}, shifted[7:0]};
      HB_HALF: data_o = {{16{~uload_i & shifted[15]}}, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// RV32 data memory: four synchronous byte-lane banks behind a valid/ready
// request/response interface, with error reporting and a post-reset zero sweep.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    ADDR_W      = 32,
  parameter bit    ZERO_INIT   = 1'b1,
  // Preload image name; consumed by the device memory-init flow when ZERO_INIT=0.
  parameter string INIT_FILE   = ""
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_hb_i,
  input  logic              req_uload_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              init_busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_we_q, rsp_we_d;
  logic [1:0]       rsp_off_q, rsp_off_d;
  logic [1:0]       rsp_hb_q, rsp_hb_d;
  logic             rsp_uload_q, rsp_uload_d;

  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic             accept;
  logic [31:0]      store_data;
  logic [3:0]       wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic [31:0]      fmt_data;

  assign req_idx = req_addr_i[IDX_W+1:2];

  // Any address bit above the word-index field means the word is outside the RAM.
  assign req_err = (req_hb_i == HB_RSVD)
                 | ((req_hb_i == HB_HALF) & req_addr_i[0])
                 | ((req_hb_i == HB_WORD) & (req_addr_i[1:0] != 2'b00))
                 | ((req_addr_i >> (IDX_W + 2)) != '0);

  assign req_ready_o = rst_ni & (state_q == S_RUN) & (~rsp_valid_q | rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;
  assign init_busy_o = (state_q == S_INIT);

  always_comb begin
    store_data = req_wdata_i;
    case (req_hb_i)
      HB_BYTE: store_data = {4{req_wdata_i[7:0]}};
      HB_HALF: store_data = {2{req_wdata_i[15:0]}};
      default: store_data = req_wdata_i;
    endcase
  end

  always_comb begin
    wr_en   = 4'b0000;
    wr_idx  = req_idx;
    wr_data = store_data;
    if (rst_ni && state_q == S_INIT) begin
      wr_en   = 4'b1111;
      wr_idx  = init_cnt_q;
      wr_data = '0;
    end else if (accept && req_we_i && !req_err) begin
      wr_en = lane_en(req_hb_i, req_addr_i[1:0]);
    end
  end

  // Banks read only on acceptance so the response word holds during a stall.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk_i) begin
      if (wr_en[gi]) begin
        mem[wr_idx] <= wr_data[gi*8 +: 8];
      end
      if (accept) begin
        rd_byte_q <= mem[req_idx];
      end
    end

    assign rd_word[gi*8 +: 8] = rd_byte_q;
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_we_d    = rsp_we_q;
    rsp_off_d   = rsp_off_q;
    rsp_hb_d    = rsp_hb_q;
    rsp_uload_d = rsp_uload_q;

    if (state_q == S_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_IDX) begin
        state_d = S_RUN;
      end
    end

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_we_d    = req_we_i;
      rsp_off_d   = req_addr_i[1:0];
      rsp_hb_d    = req_hb_i;
      rsp_uload_d = req_uload_i;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ZERO_INIT ? S_INIT : S_RUN;
      init_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_off_q   <= 2'b00;
      rsp_hb_q    <= HB_WORD;
      rsp_uload_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
      rsp_off_q   <= rsp_off_d;
      rsp_hb_q    <= rsp_hb_d;
      rsp_uload_q <= rsp_uload_d;
    end
  end

  mem_load_fmt u_load_fmt (
    .word_i  (rd_word),
    .off_i   (rsp_off_q),
    .hb_i    (rsp_hb_q),
    .uload_i (rsp_uload_q),
    .data_o  (fmt_data)
  );

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_valid_q & rsp_err_q;
  assign rsp_rdata_o = (rsp_valid_q && !rsp_err_q && !rsp_we_q) ? fmt_data : 32'h0;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: a driver issues requests and pushes
// model-predicted responses; an independent monitor compares what the DUT returns.
module tb_data_ram_ctrl;
  import data_ram_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_hb_i;
  logic        req_uload_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        init_busy_o;

  always #5 clk = ~clk;

  data_ram_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (32),
    .ZERO_INIT   (1'b1),
    .INIT_FILE   ("")
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_hb_i    (req_hb_i),
    .req_uload_i (req_uload_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .init_busy_o (init_busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  bit rand_ready = 1'b0;

  bit [31:0]   model_mem [DEPTH];
  logic [32:0] exp_q [$];   // {err, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour from the access rules, using plain arithmetic on a word array.
  function automatic logic [32:0] model_access(input logic [31:0] addr, input logic we,
                                               input logic [1:0] hb, input logic ul,
                                               input logic [31:0] wd);
    int unsigned a    = addr;
    int unsigned idx  = a / 4;
    int unsigned sh   = 8 * (a % 4);
    bit [31:0]   mask = (hb == 2'd0) ? 32'hFFFF_FFFF : (hb == 2'd1) ? 32'h0000_00FF : 32'h0000_FFFF;
    bit [31:0]   v;
    if (hb == 2'd3 || (hb == 2'd2 && (a % 2) != 0) || (hb == 2'd0 && (a % 4) != 0) ||
        a >= DEPTH * 4)
      return {1'b1, 32'h0};
    if (we) begin
      model_mem[idx] = (model_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      return {1'b0, 32'h0};
    end
    v = (model_mem[idx] >> sh) & mask;
    if (!ul && hb == 2'd1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!ul && hb == 2'd2 && v[15]) v = v | 32'hFFFF_0000;
    return {1'b0, v};
  endfunction

  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] hb,
                       input logic ul, input logic [31:0] wd);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_hb_i    = hb;
    req_uload_i = ul;
    req_wdata_i = wd;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (req_ready_o) begin
        exp_q.push_back(model_access(addr, we, hb, ul, wd));
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL issue_timeout: addr 0x%08h never accepted, expected acceptance", addr);
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Caller must already be at a negedge; counts cycles with init_busy_o high.
  task automatic measure_sweep(input string name);
    int cnt  = 0;
    int viol = 0;
    while (init_busy_o && cnt < 2000) begin
      if (req_ready_o) viol++;
      cnt++;
      @(negedge clk);
    end
    check({name, "_cycles"}, 32'(cnt), 32'(DEPTH));
    check({name, "_ready_low"}, 32'(viol), 32'd0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented response; pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni === 1'b1 && rsp_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response",
                   rsp_rdata_o, rsp_err_o);
        end else begin
          check("rsp_rdata", rsp_rdata_o, exp_q[0][31:0]);
          check("rsp_err", 32'(rsp_err_o), 32'(exp_q[0][32]));
          if (rsp_ready_i) begin
            n_rsp++;
            $display("[TB] rsp %0d: rdata=0x%08h err=%0b", n_rsp, rsp_rdata_o, rsp_err_o);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  hb;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_we_i    = 1'b0;
    req_hb_i    = HB_WORD;
    req_uload_i = 1'b0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    check("reset_rsp_rdata", rsp_rdata_o, 32'h0);
    check("reset_init_busy", 32'(init_busy_o), 32'd1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    measure_sweep("sweep");

    // Top word after the sweep, then lane formatting of a stored word.
    issue(32'h3FC, 1'b0, HB_WORD, 1'b0, 32'h0);
    issue(32'h10, 1'b1, HB_WORD, 1'b0, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) issue(32'h10 + i, 1'b0, HB_BYTE, 1'b0, 32'h0);
    issue(32'h13, 1'b0, HB_BYTE, 1'b1, 32'h0);
    issue(32'h20, 1'b1, HB_WORD, 1'b0, 32'h1234_5678);
    issue(32'h22, 1'b1, HB_HALF, 1'b0, 32'hAAAA_BEEF);
    issue(32'h20, 1'b0, HB_WORD, 1'b0, 32'h0);
    issue(32'h22, 1'b0, HB_HALF, 1'b0, 32'h0);
    issue(32'h22, 1'b0, HB_HALF, 1'b1, 32'h0);
    drain();

    // Erroring stores must leave memory untouched.
    issue(32'h04, 1'b1, HB_WORD, 1'b0, 32'hCAFE_F00D);
    issue(32'h05, 1'b1, HB_HALF, 1'b0, 32'hFFFF_FFFF);
    issue(32'h06, 1'b1, HB_WORD, 1'b0, 32'hFFFF_FFFF);
    issue(32'h10, 1'b1, HB_RSVD, 1'b0, 32'hFFFF_FFFF);
    issue(32'h400, 1'b1, HB_WORD, 1'b0, 32'hFFFF_FFFF);
    issue(32'h400, 1'b0, HB_WORD, 1'b0, 32'h0);
    issue(32'h04, 1'b0, HB_WORD, 1'b0, 32'h0);
    issue(32'h10, 1'b0, HB_WORD, 1'b0, 32'h0);
    issue(32'h00, 1'b0, HB_WORD, 1'b0, 32'h0);
    drain();

    // Backpressure: four queued loads while the response side is stalled.
    rsp_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(32'h10 + i, 1'b0, HB_BYTE, 1'(i % 2), 32'h0);
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("req_ready_stall", 32'(req_ready_o), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random response backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      hb   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (hb == HB_WORD) addr = addr & ~32'h3;
        if (hb == HB_HALF) addr = addr & ~32'h1;
      end
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h400 << $urandom_range(0, 20));
      issue(addr, 1'($urandom_range(0, 1)), hb, 1'($urandom_range(0, 1)), $urandom);
    end
    rand_ready = 1'b0;
    #1;
    rsp_ready_i = 1'b1;
    drain();

    // Reset while a response is pending: it is dropped and the sweep reruns.
    rsp_ready_i = 1'b0;
    issue(32'h10, 1'b0, HB_WORD, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    exp_q.delete();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    check("midreset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    measure_sweep("resweep");
    issue(32'h10, 1'b0, HB_WORD, 1'b0, 32'h0);
    drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
Parametrised RV32 data memory with a valid/ready request/response interface, replacing the asynchronous-read byte-lane RAM. Four byte-lane banks with synchronous read and 1-cycle read latency. Adds misalignment and range error reporting, response backpressure, and an optional post-reset zero-fill sweep. Sits between the core LSU and the data address space.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; must be a power of 2, at least 4.
ADDR_W, 32, request address width in bytes.
ZERO_INIT, 1, when 1, a zero-fill sweep runs after reset; when 0, the block is ready immediately.
INIT_FILE, "", optional hex preload; applies only when ZERO_INIT=0.

Ports:
clk_i  in  1  system clock; single clock domain.
rst_ni  in  1  reset; synchronous, active-low.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request ready.
req_addr_i  in  ADDR_W  byte address.
req_we_i  in  1  1 = store, 0 = load.
req_hb_i  in  2  access size: 00 = word, 01 = byte, 10 = half, 11 = reserved.
req_uload_i  in  1  zero-extend loads when 1.
req_wdata_i  in  32  store data, right-justified.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response ready.
rsp_rdata_o  out  32  formatted load data; 0 for stores and errors.
rsp_err_o  out  1  access error flag.
init_busy_o  out  1  high while the zero-fill sweep runs.

Behaviour:
- Reset values (rst_ni=0 sampled at a clk_i edge): rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0. State is S_INIT if ZERO_INIT=1, otherwise S_RUN. Init counter=0. Memory contents are not reset.
- Reset mid-operation: any pending response is dropped without handshake, and the sweep restarts from word 0.
- S_INIT:
  - req_ready_o=0, init_busy_o=1.
  - Each cycle writes 0 to all four lanes at the counter index, then increments the counter.
  - After writing word DEPTH_WORDS-1, the next state is S_RUN.
  - The sweep takes exactly DEPTH_WORDS cycles.
- S_RUN:
  - req_ready_o = ~rsp_valid_o | rsp_ready_i, so sustained throughput is 1 access per cycle.
  - A request is accepted when req_valid_i & req_ready_o.
- Word index = req_addr_i >> 2. Lane offset = req_addr_i[1:0].
- Lane enables:
  - Word: 1111.
  - Byte: one-hot by offset.
  - Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
- Error conditions; any one of these sets the error:
  - req_hb_i=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS (any nonzero address bit above the index field).
- An erroring access writes nothing. Its response has rsp_err_o=1 and rsp_rdata_o=0.
- Store data lane placement:
  - Byte stores take wdata[7:0], replicated to the selected lane.
  - Half stores take wdata[15:0], placed on the selected lane pair.
  - Word stores write all 32 bits.
  - Writes commit at the acceptance edge.
- Loads:
  - The banks are read on acceptance only; the registered word holds while the response is stalled.
  - Offset, size and uload are registered alongside the read word.
  - Output formatting is combinational from these registers: the selected lane(s) are shifted down, then sign-extended or, when uload=1, zero-extended.
  - Word loads ignore uload.
- Response timing:
  - rsp_valid_o rises on the edge after acceptance and holds, together with its data and error, until rsp_ready_i=1.
  - Stores also return a response, with rdata=0.
- Acceptance with rsp_valid_o=1 & rsp_ready_i=1 (simultaneous events): the old response retires and the new one appears on the next edge. There is no bubble.
- Read-after-write on back-to-back accepted requests returns the newly written data. This is inherent because the write commits before the next read.
- rsp_ready_i is ignored when rsp_valid_o=0.

Decomposition:
- Package data_ram_pkg contains:
  - size encodings HB_WORD, HB_BYTE, HB_HALF, HB_RSVD;
  - state enum S_INIT/S_RUN;
  - function lane_en(hb, off) returning the 4-bit enable vector.
- Sub-module mem_load_fmt: combinational lane select and extension, taking word, offset, hb and uload, and producing 32-bit data.
- Banks are inferred as four DEPTH_WORDS x 8 synchronous arrays in the top level.

Test Plan:
- Reset with ZERO_INIT=1, DEPTH_WORDS=256 -> init_busy_o high and req_ready_o low for exactly 256 cycles; a subsequent word load of 0x3FC returns 0x00000000, err=0.
- Word store 0x80FF7F01 at 0x10, then byte loads at 0x10..0x13 with uload=0 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; repeat at 0x13 with uload=1 -> 0x00000080.
- Half store 0xBEEF at 0x22, then word load at 0x20 -> upper 16 bits 0xBEEF, lower half unchanged; half load at 0x22, uload=0 -> 0xFFFFBEEF.
- Misaligned accesses: half at 0x05, word at 0x06, hb=11, and address 0x400 with DEPTH_WORDS=256 -> each gives err=1, rdata=0, and a subsequent read shows memory unchanged.
- Backpressure: hold rsp_ready_i=0 for 3 cycles with 4 loads queued -> req_ready_o=0 after the first acceptance and rdata stable; releasing it drains one response per cycle in order with no drop or duplicate.
- Assert rst_ni=0 for 1 cycle while a response is pending -> rsp_valid_o=0 next cycle and the sweep restarts, with init_busy_o=1 for DEPTH_WORDS cycles.
